// File: rtl/scm_cfg_pkg.sv
// Shared definitions for the statistics-counter configuration master:
// word field positions, type/op codes, register offsets and FSM states.
package scm_cfg_pkg;

   localparam int CFG_W     = 134;
   localparam int TYPE_LSB  = 124;
   localparam int OP_LSB    = 120;
   localparam int ADDR_LSB  = 64;
   localparam int DATA_LSB  = 0;

   localparam logic [3:0] REQ_TYPE = 4'b0010;
   localparam logic [2:0] RSP_TYPE = 3'b011;
   localparam logic [3:0] OP_WR    = 4'b0001;
   localparam logic [3:0] OP_RD    = 4'b0010;

   localparam logic [31:0] OFS_PROTO  = 32'h0;
   localparam logic [31:0] OFS_RESET  = 32'h1;
   localparam logic [31:0] OFS_NRTT   = 32'h2;
   localparam logic [31:0] OFS_BITLO  = 32'h8;
   localparam logic [31:0] OFS_BITHI  = 32'h9;
   localparam logic [31:0] OFS_PKTLO  = 32'hA;
   localparam logic [31:0] OFS_PKTHI  = 32'hB;
   localparam logic [31:0] OFS_TIMELO = 32'hC;
   localparam logic [31:0] OFS_TIMEHI = 32'hD;

   localparam int         NSLICE   = 6;
   localparam logic [2:0] LAST_IDX = 3'd5;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR_ISSUE,
      S_RD_ISSUE,
      S_RD_WAIT,
      S_DONE
   } state_t;

   function automatic logic [CFG_W-1:0] mk_req(
      input logic [3:0]  op,
      input logic [31:0] addr,
      input logic [31:0] data
   );
      logic [CFG_W-1:0] w;
      w = '0;
      w[TYPE_LSB +: 4] = REQ_TYPE;
      w[OP_LSB   +: 4] = op;
      w[ADDR_LSB +: 32] = addr;
      w[DATA_LSB +: 32] = data;
      return w;
   endfunction

endpackage

// File: rtl/scm_cfg_master.sv
// Configuration-chain initiator: issues parameter writes and a six-word
// statistics read sweep, then reassembles the 64-bit counters.
module scm_cfg_master
   import scm_cfg_pkg::*;
#(
   parameter logic [15:0] TIMEOUT   = 16'd1024,
   parameter logic [31:0] BASE_ADDR = 32'h7000_0000
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic               cmd_op,
   input  logic [31:0]        cmd_addr,
   input  logic [31:0]        cmd_wdata,
   output logic [CFG_W-1:0]   cout_cfg_data,
   output logic               cout_cfg_data_wr,
   input  logic               cin_cfg_ready,
   input  logic [CFG_W-1:0]   cin_cfg_data,
   input  logic               cin_cfg_data_wr,
   output logic [63:0]        stat_bit_num,
   output logic [63:0]        stat_pkt_num,
   output logic [63:0]        stat_time,
   output logic               stat_valid,
   output logic               stat_err,
   output logic               busy
);

   state_t                     state, state_n;
   logic [2:0]                 idx, idx_n;
   logic [15:0]                timer, timer_n;
   logic                       err, err_n;
   logic [NSLICE-1:0][31:0]    slice, slice_n;
   logic [31:0]                wr_addr, wr_addr_n;
   logic [31:0]                wr_data, wr_data_n;
   logic [CFG_W-1:0]           out_data, out_data_n;
   logic                       out_wr, out_wr_n;

   logic [31:0]                rd_addr;
   logic                       rsp_hit;
   logic                       unused_rsp;

   assign rd_addr = BASE_ADDR + OFS_BITLO + {29'b0, idx};

   assign rsp_hit = cin_cfg_data_wr
                 && (cin_cfg_data[TYPE_LSB +: 3] == RSP_TYPE)
                 && (cin_cfg_data[ADDR_LSB +: 32] == rd_addr);

   assign unused_rsp = ^{cin_cfg_data[133:127],
                         cin_cfg_data[123:96],
                         cin_cfg_data[63:32]};

   always_comb begin
      state_n    = state;
      idx_n      = idx;
      timer_n    = timer;
      err_n      = err;
      slice_n    = slice;
      wr_addr_n  = wr_addr;
      wr_data_n  = wr_data;
      out_data_n = out_data;
      out_wr_n   = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (cmd_valid) begin
               wr_addr_n = cmd_addr;
               wr_data_n = cmd_wdata;
               if (cmd_op) begin
                  state_n = S_RD_ISSUE;
                  idx_n   = 3'd0;
                  err_n   = 1'b0;
               end else begin
                  state_n = S_WR_ISSUE;
               end
            end
         end
         S_WR_ISSUE: begin
            if (cin_cfg_ready) begin
               out_data_n = mk_req(OP_WR, wr_addr, wr_data);
               out_wr_n   = 1'b1;
               state_n    = S_IDLE;
            end
         end
         S_RD_ISSUE: begin
            if (cin_cfg_ready) begin
               out_data_n = mk_req(OP_RD, rd_addr, 32'h0);
               out_wr_n   = 1'b1;
               timer_n    = 16'd0;
               state_n    = S_RD_WAIT;
            end
         end
         S_RD_WAIT: begin
            // a matching response in the timeout cycle takes priority
            if (rsp_hit) begin
               slice_n[idx] = cin_cfg_data[DATA_LSB +: 32];
               idx_n        = idx + 3'd1;
               state_n      = (idx == LAST_IDX) ? S_DONE : S_RD_ISSUE;
            end else if (timer == TIMEOUT - 16'd1) begin
               err_n   = 1'b1;
               state_n = S_DONE;
            end else if (timer != 16'hFFFF) begin
               timer_n = timer + 16'd1;
            end
         end
         S_DONE: begin
            state_n = S_IDLE;
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         idx      <= 3'd0;
         timer    <= 16'd0;
         err      <= 1'b0;
         slice    <= '0;
         wr_addr  <= 32'h0;
         wr_data  <= 32'h0;
         out_data <= '0;
         out_wr   <= 1'b0;
      end else begin
         state    <= state_n;
         idx      <= idx_n;
         timer    <= timer_n;
         err      <= err_n;
         slice    <= slice_n;
         wr_addr  <= wr_addr_n;
         wr_data  <= wr_data_n;
         out_data <= out_data_n;
         out_wr   <= out_wr_n;
      end
   end

   assign cmd_ready        = (state == S_IDLE);
   assign busy             = (state != S_IDLE);
   assign stat_valid       = (state == S_DONE);
   assign stat_err         = err;
   assign cout_cfg_data    = out_data;
   assign cout_cfg_data_wr = out_wr;
   assign stat_bit_num     = {slice[1], slice[0]};
   assign stat_pkt_num     = {slice[3], slice[2]};
   assign stat_time        = {slice[5], slice[4]};

endmodule

// File: tb/tb_scm_cfg_master.sv
// Directed bench for scm_cfg_master with a responder model and
// request/result scoreboards.
module tb_scm_cfg_master;

   typedef struct {
      logic [63:0] b;
      logic [63:0] p;
      logic [63:0] t;
      logic        e;
   } stat_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic          cmd_op = 1'b0;
   logic [31:0]   cmd_addr = 32'h0;
   logic [31:0]   cmd_wdata = 32'h0;
   logic [133:0]  cout_cfg_data;
   logic          cout_cfg_data_wr;
   logic          cin_cfg_ready = 1'b1;
   logic [133:0]  cin_cfg_data = '0;
   logic          cin_cfg_data_wr = 1'b0;
   logic [63:0]   stat_bit_num;
   logic [63:0]   stat_pkt_num;
   logic [63:0]   stat_time;
   logic          stat_valid;
   logic          stat_err;
   logic          busy;

   scm_cfg_master dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .cmd_valid        (cmd_valid),
      .cmd_ready        (cmd_ready),
      .cmd_op           (cmd_op),
      .cmd_addr         (cmd_addr),
      .cmd_wdata        (cmd_wdata),
      .cout_cfg_data    (cout_cfg_data),
      .cout_cfg_data_wr (cout_cfg_data_wr),
      .cin_cfg_ready    (cin_cfg_ready),
      .cin_cfg_data     (cin_cfg_data),
      .cin_cfg_data_wr  (cin_cfg_data_wr),
      .stat_bit_num     (stat_bit_num),
      .stat_pkt_num     (stat_pkt_num),
      .stat_time        (stat_time),
      .stat_valid       (stat_valid),
      .stat_err         (stat_err),
      .busy             (busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int fails = 0;
   int ncyc = 0;
   int strobes = 0;
   int last_strobe = 0;
   int svalid = 0;

   logic [133:0] word_q[$];
   stat_t        stat_q[$];

   logic         drop_en = 1'b0;
   logic         inj_en = 1'b0;
   logic [31:0]  dbase = 32'h0;

   always @(posedge clk) ncyc <= ncyc + 1;

   task automatic chk(input string tag, input logic [133:0] obs,
                      input logic [133:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [133:0] exp_req(input logic [3:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] d);
      return {6'b0, 4'b0010, op, 24'b0, a, 32'b0, d};
   endfunction

   function automatic logic [133:0] rsp_word(input logic [31:0] a,
                                            input logic [31:0] d);
      return {6'b0, 4'b0011, 4'b0000, 24'b0, a, 32'b0, d};
   endfunction

   // output monitor: request words and sweep results against the queues
   initial forever begin
      @(negedge clk);
      if (rst_n) begin
         if (cout_cfg_data_wr) begin
            strobes++;
            last_strobe = ncyc;
            if (word_q.size() == 0)
               chk("unexpected_strobe", 134'(word_q.size()), 134'd1);
            else
               chk("req_word", cout_cfg_data, word_q.pop_front());
         end
         if (stat_valid) begin
            stat_t e;
            svalid++;
            if (stat_q.size() == 0) begin
               chk("unexpected_stat_valid", 134'(stat_q.size()), 134'd1);
            end else begin
               e = stat_q.pop_front();
               chk("stat_bit_num", 134'(stat_bit_num), 134'(e.b));
               chk("stat_pkt_num", 134'(stat_pkt_num), 134'(e.p));
               chk("stat_time", 134'(stat_time), 134'(e.t));
               chk("stat_err_at_valid", 134'(stat_err), 134'(e.e));
            end
         end
      end
   end

   // responder: answers each read three cycles later with dbase + 0x11*(idx+1)
   initial begin : responder
      logic        pend;
      logic        upend;
      int          dly;
      logic [31:0] paddr;
      pend = 1'b0;
      upend = 1'b0;
      dly = 0;
      paddr = 32'h0;
      forever begin
         @(negedge clk);
         cin_cfg_data_wr = 1'b0;
         cin_cfg_data = '0;
         if (!rst_n) begin
            pend = 1'b0;
            upend = 1'b0;
         end else begin
            if (upend) begin
               cin_cfg_data = rsp_word(32'h7000_000C, 32'hDEAD_BEEF);
               cin_cfg_data_wr = 1'b1;
               upend = 1'b0;
            end else if (pend) begin
               if (dly == 0) begin
                  cin_cfg_data = rsp_word(paddr,
                     dbase + 32'h11 * (paddr - 32'h7000_0008 + 32'h1));
                  cin_cfg_data_wr = 1'b1;
                  pend = 1'b0;
               end else begin
                  dly--;
               end
            end
            if (cout_cfg_data_wr && cout_cfg_data[123:120] == 4'b0010) begin
               paddr = cout_cfg_data[95:64];
               if (!(drop_en && paddr == 32'h7000_000B)) begin
                  pend = 1'b1;
                  dly = 2;
               end
               if (inj_en && paddr == 32'h7000_0008) upend = 1'b1;
            end
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic send(input logic op, input logic [31:0] a,
                       input logic [31:0] d, output int acc);
      chk("cmd_ready_before_cmd", 134'(cmd_ready), 134'd1);
      cmd_valid = 1'b1;
      cmd_op = op;
      cmd_addr = a;
      cmd_wdata = d;
      acc = ncyc;
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_strobes(input int target, input int bound,
                               input string tag);
      int n;
      n = 0;
      while (strobes < target && n < bound) begin
         tick();
         n++;
      end
      chk(tag, 134'(strobes >= target), 134'd1);
   endtask

   task automatic wait_stat(input int target, input int bound,
                            input string tag);
      int n;
      n = 0;
      while (svalid < target && n < bound) begin
         tick();
         n++;
      end
      chk(tag, 134'(svalid >= target), 134'd1);
   endtask

   task automatic push_reads(input int n);
      for (int i = 0; i < n; i++)
         word_q.push_back(exp_req(4'b0010, 32'h7000_0008 + i, 32'h0));
   endtask

   initial begin : main
      int acc;
      int s0;
      int v0;
      int t0;
      stat_t es;

      repeat (3) tick();
      chk("rst_wr", 134'(cout_cfg_data_wr), 134'd0);
      chk("rst_data", cout_cfg_data, 134'd0);
      chk("rst_stats", 134'({stat_bit_num, stat_pkt_num}), 134'd0);
      chk("rst_flags", 134'({stat_time, stat_valid, stat_err, busy}), 134'd0);
      rst_n = 1'b1;
      tick();
      chk("cmd_ready_after_reset", 134'(cmd_ready), 134'd1);

      // write with ready high
      s0 = strobes;
      word_q.push_back(exp_req(4'b0001, 32'h7000_0002, 32'h64));
      send(1'b0, 32'h7000_0002, 32'h64, acc);
      wait_strobes(s0 + 1, 10, "wr_strobe_seen");
      chk("wr_latency", 134'(last_strobe), 134'(acc + 2));
      repeat (3) tick();
      chk("wr_one_strobe", 134'(strobes - s0), 134'd1);
      chk("wr_idle_busy", 134'(busy), 134'd0);

      // write with chain back-pressure
      cin_cfg_ready = 1'b0;
      s0 = strobes;
      word_q.push_back(exp_req(4'b0001, 32'h7000_0002, 32'h64));
      send(1'b0, 32'h7000_0002, 32'h64, acc);
      for (int i = 0; i < 5; i++) begin
         chk("bp_busy", 134'(busy), 134'd1);
         chk("bp_no_strobe", 134'(strobes - s0), 134'd0);
         tick();
      end
      cin_cfg_ready = 1'b1;
      wait_strobes(s0 + 1, 10, "bp_strobe_seen");
      repeat (4) tick();
      chk("bp_one_strobe", 134'(strobes - s0), 134'd1);

      // full sweep
      dbase = 32'h0;
      v0 = svalid;
      push_reads(6);
      es = '{b: 64'h22_0000_0011, p: 64'h44_0000_0033,
             t: 64'h66_0000_0055, e: 1'b0};
      stat_q.push_back(es);
      send(1'b1, 32'h0, 32'h0, acc);
      wait_stat(v0 + 1, 200, "sweep1_done");
      tick();
      chk("sweep1_valid_pulse", 134'(stat_valid), 134'd0);
      repeat (3) tick();
      chk("sweep1_one_valid", 134'(svalid - v0), 134'd1);
      chk("sweep1_err", 134'(stat_err), 134'd0);

      // 4th read dropped: timeout
      dbase = 32'h1000;
      drop_en = 1'b1;
      v0 = svalid;
      push_reads(4);
      es = '{b: 64'h1022_0000_1011, p: 64'h44_0000_1033,
             t: 64'h66_0000_0055, e: 1'b1};
      stat_q.push_back(es);
      send(1'b1, 32'h0, 32'h0, acc);
      t0 = ncyc;
      wait_stat(v0 + 1, 3000, "sweep2_done");
      chk("sweep2_waited_timeout", 134'((ncyc - t0) >= 1024), 134'd1);
      repeat (3) tick();
      chk("sweep2_err_sticky", 134'(stat_err), 134'd1);
      chk("sweep2_one_valid", 134'(svalid - v0), 134'd1);
      drop_en = 1'b0;

      // unsolicited response during idx 0 wait
      dbase = 32'h2000;
      inj_en = 1'b1;
      v0 = svalid;
      push_reads(6);
      es = '{b: 64'h2022_0000_2011, p: 64'h2044_0000_2033,
             t: 64'h2066_0000_2055, e: 1'b0};
      stat_q.push_back(es);
      send(1'b1, 32'h0, 32'h0, acc);
      chk("sweep3_err_cleared", 134'(stat_err), 134'd0);
      wait_stat(v0 + 1, 200, "sweep3_done");
      inj_en = 1'b0;
      repeat (2) tick();

      // reset mid-sweep
      dbase = 32'h3000;
      s0 = strobes;
      v0 = svalid;
      push_reads(6);
      send(1'b1, 32'h0, 32'h0, acc);
      wait_strobes(s0 + 2, 50, "abort_progress");
      rst_n = 1'b0;
      #1;
      chk("abort_stats", 134'({stat_bit_num, stat_pkt_num}), 134'd0);
      chk("abort_flags",
          134'({stat_time, stat_valid, stat_err, busy, cout_cfg_data_wr}),
          134'd0);
      chk("abort_data", cout_cfg_data, 134'd0);
      word_q.delete();
      tick();
      rst_n = 1'b1;
      tick();
      chk("abort_idle", 134'({cmd_ready, busy}), 134'b10);
      repeat (20) tick();
      chk("abort_no_valid", 134'(svalid - v0), 134'd0);

      // sweep after reset
      dbase = 32'h4000;
      v0 = svalid;
      push_reads(6);
      es = '{b: 64'h4022_0000_4011, p: 64'h4044_0000_4033,
             t: 64'h4066_0000_4055, e: 1'b0};
      stat_q.push_back(es);
      send(1'b1, 32'h0, 32'h0, acc);
      wait_stat(v0 + 1, 200, "sweep4_done");
      repeat (5) tick();
      chk("words_left", 134'(word_q.size()), 134'd0);
      chk("stats_left", 134'(stat_q.size()), 134'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               checks, fails);
      $finish;
   end

endmodule
